// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave in front of a small register file.
// Frame (MSB first): rw | address[ADDR_W] | payload[DATA_W].
//   rw = 0 : write payload to regs[address], pulse wr_strobe for one sclk.
//   rw = 1 : shift regs[address] out on miso during the payload bits.
// All state lives in the sclk domain; cs high asynchronously idles the frame
// logic and the falling-edge miso register, but keeps the register file.
// The frame phase is decoded from the bit counter and exported on
// dbg_state_o (0 = CMD, 1 = ADDR, 2 = DATA, 3 = DONE).
module spi_slave_regfile #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                     sclk,
   input  logic                     i_reset_n,
   input  logic                     cs,
   input  logic                     mosi,
   output logic                     miso,
   output logic [DATA_W-1:0]        dout,
   output logic [ADDR_W-1:0]        dout_addr,
   output logic                     wr_strobe,
   output logic [DEPTH*DATA_W-1:0]  regs_flat,
   output logic [1:0]               dbg_state_o
);

   // Frame length and bit-counter landmarks.
   localparam int F     = 1 + ADDR_W + DATA_W;
   localparam int CNT_W = $clog2(F + 1);

   localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ADDR_END = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(F - 1);
   localparam logic [CNT_W-1:0] CNT_DONE     = CNT_W'(F);

   // One extra bit so the range check is meaningful even when DEPTH
   // is an exact power of two.
   localparam logic [ADDR_W:0]  DEPTH_X      = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_CMD  = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   state_e                state;

   logic [CNT_W-1:0]      cnt_q,    cnt_d;
   logic                  rw_q,     rw_d;
   logic [ADDR_W-1:0]     addr_q,   addr_d;
   logic [DATA_W-1:0]     data_q,   data_d;
   logic                  strobe_q, strobe_d;
   logic                  miso_q,   miso_d;
   logic                  commit;
   logic                  in_range;

   logic [DATA_W-1:0]     regs_q [DEPTH];
   logic [DATA_W-1:0]     dout_q;
   logic [ADDR_W-1:0]     dout_addr_q;
   logic [DATA_W-1:0]     rd_word;
   logic [DATA_W-1:0]     rd_shift;

   assign in_range = ({1'b0, addr_q} < DEPTH_X);

   // Frame state register: reset first, then cs high idles the frame.
   always_ff @(posedge sclk or negedge i_reset_n or posedge cs) begin
      if (!i_reset_n) begin
         cnt_q    <= '0;
         rw_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         strobe_q <= 1'b0;
      end else if (cs) begin
         cnt_q    <= '0;
         rw_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         strobe_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         rw_q     <= rw_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         strobe_q <= strobe_d;
      end
   end

   // Phase decode and next-state: shift fields in, detect the write commit.
   always_comb begin
      state    = ST_DONE;
      cnt_d    = cnt_q;
      rw_d     = rw_q;
      addr_d   = addr_q;
      data_d   = data_q;
      strobe_d = 1'b0;
      commit   = 1'b0;

      if (cnt_q == CNT_ZERO) begin
         state = ST_CMD;
      end else if (cnt_q <= CNT_ADDR_END) begin
         state = ST_ADDR;
      end else if (cnt_q < CNT_DONE) begin
         state = ST_DATA;
      end else begin
         state = ST_DONE;
      end

      case (state)
         ST_CMD: begin
            rw_d  = mosi;
            cnt_d = cnt_q + CNT_ONE;
         end
         ST_ADDR: begin
            addr_d = ADDR_W'({addr_q, mosi});
            cnt_d  = cnt_q + CNT_ONE;
         end
         ST_DATA: begin
            data_d = DATA_W'({data_q, mosi});
            cnt_d  = cnt_q + CNT_ONE;
            // The edge sampling the final payload bit commits a write.
            if ((cnt_q == CNT_LAST) && !rw_q && in_range) begin
               commit   = 1'b1;
               strobe_d = 1'b1;
            end
         end
         ST_DONE: begin
            // Extra clocks after a full frame are ignored until cs rises.
            cnt_d = cnt_q;
         end
         default: begin
            cnt_d = cnt_q;
         end
      endcase
   end

   // Register file and last-write reporting; untouched by cs.
   always_ff @(posedge sclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            regs_q[k] <= '0;
         end
         dout_q      <= '0;
         dout_addr_q <= '0;
      end else if (commit) begin
         regs_q[addr_q] <= data_d;
         dout_q         <= data_d;
         dout_addr_q    <= addr_q;
      end
   end

   // Read data selection: out-of-range addresses read as zero, and the
   // payload bit for the upcoming rising edge is chosen from the counter.
   always_comb begin
      rd_word  = '0;
      rd_shift = '0;
      miso_d   = 1'b0;
      if (in_range) begin
         rd_word = regs_q[addr_q];
      end
      rd_shift = rd_word >> (CNT_LAST - cnt_q);
      if ((state == ST_DATA) && rw_q) begin
         miso_d = rd_shift[0];
      end
   end

   // miso launches on the falling edge so the master samples it on the rise.
   always_ff @(negedge sclk or negedge i_reset_n or posedge cs) begin
      if (!i_reset_n) begin
         miso_q <= 1'b0;
      end else if (cs) begin
         miso_q <= 1'b0;
      end else begin
         miso_q <= miso_d;
      end
   end

   // Parallel view of the register file for the core.
   always_comb begin
      regs_flat = '0;
      for (int k = 0; k < DEPTH; k++) begin
         regs_flat[k*DATA_W +: DATA_W] = regs_q[k];
      end
   end

   assign miso        = miso_q;
   assign dout        = dout_q;
   assign dout_addr   = dout_addr_q;
   assign wr_strobe   = strobe_q;
   assign dbg_state_o = state;

endmodule
